pipo_rr_load_arbiter: RTL and testbench
=======================================

Name: pipo_rr_load_arbiter

Overview:
Round-robin load controller that shares one parallel-in/parallel-out data register between NUM_REQ requesters. Each cycle the block is free to arbitrate, it grants one pending requester and loads that requester's word into the register. It holds the word for HOLD_CYCLES cycles, then either re-arbitrates back-to-back or clears the register to zero. The block sits between producer agents and a single downstream parallel consumer.

Parameters:
- DATA_WIDTH, 8, width of each requester word and of reg_out.
- NUM_REQ, 4, number of requesters; legal range 2..16.
- HOLD_CYCLES, 2, cycles a loaded word stays valid; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request; bit i belongs to requester i.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- gnt  output  NUM_REQ  registered one-hot grant pulse, one cycle wide.
- reg_out  output  DATA_WIDTH  parallel register contents.
- out_valid  output  1  reg_out holds a granted word.
- out_owner  output  $clog2(NUM_REQ)  index of the requester whose word is in reg_out.
- busy  output  1  high while the FSM is in HOLD.

Behaviour:
- Reset: applied on a clk edge while reset=1. It forces gnt=0, reg_out=0, out_valid=0, out_owner=0, busy=0, state=IDLE, rr_ptr=0 and hold counter=0. Reset overrides every other event, including mid-HOLD; a word in flight is discarded.
- Reset of the arbitration pointer: rr_ptr=0 means req[0] has highest priority first.
- States: IDLE and HOLD.
- Arbitration (an "arb edge"):
  - Occurs at any edge in IDLE with |req=1.
  - Also occurs at the last HOLD edge (counter==0) with |req=1.
  - Winner w = first set bit of req scanned from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
  - Results registered at that edge: gnt=onehot(w), reg_out=req_data[w], out_owner=w, out_valid=1, busy=1, counter=HOLD_CYCLES-1, rr_ptr=(w+1) mod NUM_REQ, state=HOLD.
- Latency: req sampled at edge E gives gnt, reg_out and out_valid visible in the cycle after E.
- gnt: high exactly one cycle per grant; otherwise 0.
- HOLD, counter != 0: decrement the counter. reg_out, out_owner and out_valid hold.
- HOLD, counter == 0:
  - If |req=1: arb edge as above. out_valid stays 1 with no bubble.
  - Else: reg_out=0, out_valid=0, busy=0, state=IDLE. out_owner holds its last value.
- IDLE with req=0: reg_out stays 0; nothing changes.
- Requester rule:
  - req is level-sensitive. req_data[i] is sampled only on the arb edge that grants i.
  - A requester that keeps req high after its gnt is a new request. It is served again only after all other pending requesters (round-robin fairness).
- A word is valid for exactly HOLD_CYCLES cycles.
  - Each grant occupies HOLD_CYCLES cycles.
  - Continuous contention gives one grant per HOLD_CYCLES cycles.
  - With HOLD_CYCLES=1, gnt can fire every cycle.
- Request changes between arb edges have no effect.
- req bits for requesters not present are simply 0; no error state exists.

Decomposition:
- Package pipo_arb_pkg:
  - state_e enum {IDLE, HOLD}.
  - Function onehot_to_idx.
  - Constant defaults for DATA_WIDTH, NUM_REQ, HOLD_CYCLES.
- Sub-module rr_picker: purely combinational. Inputs req and rr_ptr; outputs any_req, winner index and winner one-hot.
- The top holds the FSM, hold counter, rr_ptr and the data register with its mux.

Test Plan:
- Reset, then req=0 for 10 cycles -> gnt=0, reg_out=0, out_valid=0, busy=0 throughout.
- req=4'b0001, req_data[0]=8'hA5 sampled at E1, req dropped after gnt:
  - gnt=0001 for one cycle.
  - reg_out=8'hA5, out_valid=1, out_owner=0 for exactly 2 cycles.
  - Then reg_out=0, out_valid=0, state IDLE.
- req=4'b1111 held, req_data[i]=8'h10+i:
  - Owners sequence 0,1,2,3,0.
  - Each word lasts 2 cycles; out_valid never drops; gnt pulses every 2 cycles.
- After owner 1 is served, req=4'b1010 held -> next owner 3, then 1, then 3.
- reset=1 for one edge during the first HOLD cycle, then req=4'b1111 -> reg_out=0 and out_valid=0 immediately after reset; first grant goes to owner 0.
- HOLD_CYCLES=1, req=4'b0100 held, req_data[2]=8'h3C -> gnt=0100 every cycle, reg_out=8'h3C, out_valid stays 1.

Source files
------------

// File: rtl/pipo_arb_pkg.sv
// Shared types, default parameters and helpers for the round-robin PIPO load arbiter.
package pipo_arb_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_HOLD_CYCLES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Encoder for one-hot vectors up to 16 bits wide, which covers the largest legal requester count.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after rr_ptr, wrapping around.
module rr_picker
  import pipo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               any_req,
  output logic [IW-1:0]      winner_idx,
  output logic [NUM_REQ-1:0] winner_oh
);

  logic found;

  // NOTE: every signal driven here gets a default at the top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    int idx;
    winner_oh = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        winner_oh[idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  assign any_req    = |req;
  assign winner_idx = IW'(onehot_to_idx(16'(winner_oh)));

endmodule

// File: rtl/pipo_rr_load_arbiter.sv
// Shares one parallel data register between NUM_REQ requesters, granting round-robin and holding each word HOLD_CYCLES cycles.
module pipo_rr_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         reg_out,
  output logic                          out_valid,
  output logic [$clog2(NUM_REQ)-1:0]    out_owner,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q;
  logic [IW-1:0]          owner_q;

  logic                   any_req;
  logic [IW-1:0]          win_idx;
  logic [NUM_REQ-1:0]     win_oh;
  logic                   arb;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .any_req    (any_req),
    .winner_idx (win_idx),
    .winner_oh  (win_oh)
  );

  // Arbitrate when idle, or on the final hold cycle so contention continues without a bubble.
  assign arb      = any_req && ((state_q == IDLE) || (cnt_q == '0));
  assign rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + IW'(1);
  assign data_d   = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      owner_q  <= '0;
    end else begin
      gnt_q <= '0;
      if (arb) begin
        state_q  <= HOLD;
        cnt_q    <= CW'(HOLD_CYCLES - 1);
        rr_ptr_q <= rr_ptr_d;
        gnt_q    <= win_oh;
        data_q   <= data_d;
        valid_q  <= 1'b1;
        owner_q  <= win_idx;
      end else if (state_q == HOLD) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          state_q <= IDLE;
          data_q  <= '0;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign gnt       = gnt_q;
  assign reg_out   = data_q;
  assign out_valid = valid_q;
  assign out_owner = owner_q;
  assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_pipo_rr_load_arbiter.sv
// Directed bench for pipo_rr_load_arbiter: a HOLD_CYCLES=2 instance and a HOLD_CYCLES=1 instance.
module tb_pipo_rr_load_arbiter;

  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic [3:0]  req_a, req_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  gnt_a, gnt_b;
  logic [7:0]  reg_a, reg_b;
  logic        valid_a, valid_b;
  logic [1:0]  owner_a, owner_b;
  logic        busy_a, busy_b;

  int tests_run = 0;
  int failed    = 0;

  // Observed bundle layout: {gnt[3:0], reg_out[7:0], out_valid, out_owner[1:0], busy}
  logic [15:0] obs, exp_v;

  always #5 clk = ~clk;

  pipo_rr_load_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset_a), .req(req_a), .req_data(data_a),
    .gnt(gnt_a), .reg_out(reg_a), .out_valid(valid_a), .out_owner(owner_a), .busy(busy_a)
  );

  pipo_rr_load_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset_b), .req(req_b), .req_data(data_b),
    .gnt(gnt_b), .reg_out(reg_b), .out_valid(valid_b), .out_owner(owner_b), .busy(busy_b)
  );

  task automatic reset_dut_a();
    @(negedge clk);
    reset_a = 1'b1;
    req_a   = 4'b0000;
    @(negedge clk);
    reset_a = 1'b0;
  endtask

  task automatic test_reset();
    reset_a = 1'b1; reset_b = 1'b1;
    req_a = '0; req_b = '0; data_a = '0; data_b = '0;
    repeat (2) @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0;
    obs = {gnt_a, reg_a, valid_a, owner_a, busy_a};
    tests_run++;
    if (obs !== 16'h0000) begin
      failed++;
      $display("FAIL reset_a: got %h want %h", obs, 16'h0000);
    end
    obs = {gnt_b, reg_b, valid_b, owner_b, busy_b};
    tests_run++;
    if (obs !== 16'h0000) begin
      failed++;
      $display("FAIL reset_b: got %h want %h", obs, 16'h0000);
    end
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      obs = {gnt_a, reg_a, valid_a, owner_a, busy_a};
      tests_run++;
      if (obs !== 16'h0000) begin
        failed++;
        $display("FAIL idle cycle %0d: got %h want %h", c, obs, 16'h0000);
      end
    end
  endtask

  task automatic test_single_grant();
    data_a[7:0] = 8'hA5;
    req_a       = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_a = 4'b0000;
      obs   = {gnt_a, reg_a, valid_a, owner_a, busy_a};
      exp_v = {(c == 0) ? 4'b0001 : 4'b0000, 8'hA5, 1'b1, 2'd0, 1'b1};
      tests_run++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL single hold cycle %0d: got %h want %h", c, obs, exp_v);
      end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      obs   = {gnt_a, reg_a, valid_a, owner_a, busy_a};
      exp_v = {4'b0000, 8'h00, 1'b0, 2'd0, 1'b0};
      tests_run++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL single release cycle %0d: got %h want %h", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut_a();
    for (int i = 0; i < 4; i++) data_a[i*8 +: 8] = 8'h10 + 8'(i);
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        obs   = {gnt_a, reg_a, valid_a, owner_a, busy_a};
        exp_v = {(c == 0) ? (4'b0001 << (k % 4)) : 4'b0000,
                 8'h10 + 8'(k % 4), 1'b1, 2'(k % 4), 1'b1};
        tests_run++;
        if (obs !== exp_v) begin
          failed++;
          $display("FAIL b2b grant %0d cycle %0d: got %h want %h", k, c, obs, exp_v);
        end
      end
    end
    req_a = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [1:0] seq [5];
    seq = '{2'd0, 2'd1, 2'd3, 2'd1, 2'd3};
    reset_dut_a();
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        obs   = {gnt_a, reg_a, valid_a, owner_a, busy_a};
        exp_v = {(c == 0) ? (4'b0001 << seq[k]) : 4'b0000,
                 8'h10 + 8'(seq[k]), 1'b1, seq[k], 1'b1};
        tests_run++;
        if (obs !== exp_v) begin
          failed++;
          $display("FAIL fair grant %0d cycle %0d: got %h want %h", k, c, obs, exp_v);
        end
        if (k == 1 && c == 1) req_a = 4'b1010;
      end
    end
    req_a = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    reset_dut_a();
    req_a = 4'b1111;
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    reset_a = 1'b0;
    obs = {gnt_a, reg_a, valid_a, owner_a, busy_a};
    tests_run++;
    if (obs !== 16'h0000) begin
      failed++;
      $display("FAIL reset mid hold: got %h want %h", obs, 16'h0000);
    end
    @(negedge clk);
    obs   = {gnt_a, reg_a, valid_a, owner_a, busy_a};
    exp_v = {4'b0001, 8'h10, 1'b1, 2'd0, 1'b1};
    tests_run++;
    if (obs !== exp_v) begin
      failed++;
      $display("FAIL first grant after reset: got %h want %h", obs, exp_v);
    end
    req_a = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold_one();
    data_b[23:16] = 8'h3C;
    req_b         = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      obs   = {gnt_b, reg_b, valid_b, owner_b, busy_b};
      exp_v = {4'b0100, 8'h3C, 1'b1, 2'd2, 1'b1};
      tests_run++;
      if (obs !== exp_v) begin
        failed++;
        $display("FAIL hold1 cycle %0d: got %h want %h", c, obs, exp_v);
      end
    end
    req_b = 4'b0000;
    @(negedge clk);
    obs   = {gnt_b, reg_b, valid_b, owner_b, busy_b};
    exp_v = {4'b0000, 8'h00, 1'b0, 2'd2, 1'b0};
    tests_run++;
    if (obs !== exp_v) begin
      failed++;
      $display("FAIL hold1 release: got %h want %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_grant();
    test_back_to_back();
    test_fairness();
    test_reset_mid_hold();
    test_hold_one();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
